// File: rtl/matraptor_row_dispatcher.sv
// MatRaptor row dispatcher: streams row-ordered sparse elements to PEs,
// one whole row per PE, using a one-element lookahead to flag row ends.
module matraptor_row_dispatcher #(
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 16,
  parameter int NUM_PES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_val,
  input  logic [IDX_W-1:0]   in_row,
  input  logic [IDX_W-1:0]   in_col,
  input  logic               in_last,
  output logic [NUM_PES-1:0] pe_valid,
  input  logic [NUM_PES-1:0] pe_ready,
  output logic [DATA_W-1:0]  pe_val,
  output logic [IDX_W-1:0]   pe_row,
  output logic [IDX_W-1:0]   pe_col,
  output logic               pe_row_end,
  output logic               pe_last,
  input  logic [NUM_PES-1:0] pe_row_done,
  output logic [IDX_W-1:0]   row_cnt,
  output logic               busy,
  output logic               done,
  output logic               err_spurious
);
  localparam int PW = $clog2(NUM_PES);
  localparam logic [PW:0] NPL = (PW+1)'(NUM_PES);

  typedef enum logic [2:0] {
    S_IDLE, S_ROW, S_FLUSH, S_WAIT, S_DONE
  } state_t;

  state_t state, state_n;

  logic               h_v, h_last;
  logic [DATA_W-1:0]  h_val;
  logic [IDX_W-1:0]   h_row, h_col;
  logic [NUM_PES-1:0] pe_busy, busy_n, clr_busy;
  logic [PW-1:0]      rr_ptr, cur_pe, sel, off, rr_nxt;
  logic [PW:0]        sum;
  logic [2*NUM_PES-1:0] free2;
  logic [NUM_PES-1:0] rot;
  logic sel_ok, out_fire, accept, row_stays, alloc;

  // Rotate the free mask so the lowest set bit is the first
  // free PE at or after rr_ptr.
  always_comb begin
    free2 = {~pe_busy, ~pe_busy} >> rr_ptr;
    rot = free2[NUM_PES-1:0];
    sel_ok = |rot;
    off = '0;
    for (int k = NUM_PES-1; k >= 0; k--)
      if (rot[k]) off = PW'(k);
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= NPL) sum = sum - NPL;
    sel = sum[PW-1:0];
    rr_nxt = (sel == PW'(NUM_PES-1)) ? '0 : sel + PW'(1);
  end

  assign pe_val = h_val;
  assign pe_row = h_row;
  assign pe_col = h_col;

  always_comb begin
    pe_valid = '0;
    if (!rst && h_v && (h_last || in_valid))
      pe_valid[cur_pe] = 1'b1;
    out_fire = |(pe_valid & pe_ready);
    pe_row_end = !rst && (h_last || (in_row != h_row));
    pe_last = !rst && h_last;
    row_stays = (state == S_ROW) && !(out_fire && pe_row_end);
    in_ready = !rst
      && (state == S_IDLE || state == S_ROW)
      && (!h_v || out_fire)
      && (row_stays || sel_ok);
    accept = in_valid && in_ready;
    alloc = accept && !row_stays;
    clr_busy = pe_busy & ~pe_row_done;
    busy_n = clr_busy;
    if (alloc) busy_n[sel] = 1'b1;
    busy = !rst && (state != S_IDLE);
    done = !rst && (state == S_DONE);
    state_n = state;
    unique case (state)
      S_IDLE, S_ROW: begin
        if (accept && in_last)
          state_n = S_FLUSH;
        else if (accept)
          state_n = S_ROW;
        else if (out_fire && pe_row_end)
          state_n = S_IDLE;
      end
      S_FLUSH: if (out_fire) state_n = S_WAIT;
      S_WAIT:  if (clr_busy == '0) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      h_v          <= 1'b0;
      h_last       <= 1'b0;
      h_val        <= '0;
      h_row        <= '0;
      h_col        <= '0;
      pe_busy      <= '0;
      rr_ptr       <= '0;
      cur_pe       <= '0;
      row_cnt      <= '0;
      err_spurious <= 1'b0;
    end else begin
      state   <= state_n;
      pe_busy <= busy_n;
      if (|(pe_row_done & ~pe_busy))
        err_spurious <= 1'b1;
      if (out_fire) begin
        h_v    <= 1'b0;
        h_last <= 1'b0;
      end
      if (accept) begin
        h_v    <= 1'b1;
        h_last <= in_last;
        h_val  <= in_val;
        h_row  <= in_row;
        h_col  <= in_col;
      end
      if (alloc) begin
        cur_pe  <= sel;
        rr_ptr  <= rr_nxt;
        row_cnt <= row_cnt + IDX_W'(1);
      end
    end
  end
endmodule
